alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Front end of the 16-bit ALU. Accepts encoded instructions over a valid/ready handshake and decodes them into ALU mode and operands. Holds an 8-entry register file, drives the ALU operand/mode inputs, captures the ALU result, and writes it back. Maintains a Z/N/V status register. It sits between the fetch stage and the combinational ALU instance.

Parameters:
DATA_W, 16, datapath width (only 16 verified)
REG_CNT, 8, number of general registers (index width 3)
IMM_W, 6, immediate field width, zero-extended to DATA_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
instr  in  16  instruction word: [15:13] op, [12:10] rd, [9:7] rs1, [6] use_imm, [5:3] rs2 or [5:0] imm6
instr_valid  in  1  instr is valid this cycle
instr_ready  out  1  block can accept an instruction
alu_in1  out  16  operand 1 to ALU (registered)
alu_in2  out  16  operand 2 to ALU (registered)
alu_mode  out  3  ALU mode (registered), equals op
alu_out  in  16  ALU combinational result
alu_flags  in  16  ALU flags; bit1 = negative, bit2 = overflow, other bits ignored
res_valid  out  1  one-cycle pulse on writeback
res_rd  out  3  destination index of the writeback
res_data  out  16  value written back
status  out  3  {V,N,Z} status register
dbg_addr  in  3  debug read index
dbg_data  out  16  combinational read of reg[dbg_addr]

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; all regs = 0; alu_in1/alu_in2 = 0; alu_mode = 0.
  - status = 0; res_valid = 0; res_rd = 0; res_data = 0.
  - instr_ready = 0 while rst_n is low.
  - Reset mid-operation aborts the instruction: no writeback, no status update.
- FSM IDLE -> OPR -> CAP -> WB -> IDLE. instr_ready = (state == IDLE) and rst_n.
- IDLE:
  - On instr_valid & instr_ready, latch instr and go to OPR.
  - instr_valid without ready is held off. The source must keep instr stable until accepted.
- OPR:
  - alu_in1 <= reg[rs1].
  - alu_in2 <= use_imm ? zero-extended imm6 : reg[rs2].
  - alu_mode <= op.
  - Go to CAP.
- CAP:
  - ALU inputs are stable for a full cycle.
  - Capture alu_out into result register; capture N = alu_flags[1], V = alu_flags[2].
  - Compute Z = (alu_out == 0) locally.
  - Go to WB.
- WB:
  - If rd != 0, reg[rd] <= result. reg0 reads as 0 and writes to it are discarded.
  - res_valid = 1 for this cycle only; res_rd = rd; res_data = result, reported even when rd = 0.
  - status <= {V,N,Z}. Go to IDLE.
- Latency and throughput:
  - Acceptance edge to res_valid: 3 cycles.
  - Throughput: 1 instruction per 4 cycles.
- Read-after-write: the next instruction reads its operands in OPR, after the WB edge, so it sees the updated value. No bypass is needed.
- alu_in1/alu_in2/alu_mode hold their last value outside OPR. The ALU output is sampled only in CAP.
- NOT (op 6) still drives alu_in2 per the decode; the ALU ignores it. Shifts pass the full 16-bit alu_in2.
- dbg_data is combinational, reflects reg updates the cycle after WB, and reads 0 for index 0.

Decomposition:
- Shared package alu_pkg:
  - op constants ADD=0, SUBST=1, SHIFTR=2, SHIFTL=3, AND=4, OR=5, NOT=6, XOR=7.
  - FSM state encoding (2 bits).
  - instr field bit positions.
  - status bit positions (Z=0, N=1, V=2).
- Sub-module alu_regfile:
  - 8x16 registers, reg0 reads 0.
  - Two combinational read ports plus one debug read port.
  - One synchronous write port with enable; synchronous active-low reset to 0.

Test Plan:
1. Reset: hold rst_n low for 2 cycles with instr_valid = 1 -> instr_ready = 0, res_valid = 0, status = 0, dbg_data = 0 for every index.
2. Immediate ADD: ADD r1 = r0 + imm 5 (use_imm = 1), ALU model in loop.
   - res_valid exactly 3 cycles after acceptance, res_rd = 1, res_data = 0x0005, status Z = 0.
   - dbg_data(1) = 0x0005.
3. Read-after-write: ADD r2 = r1 + imm 3 issued back-to-back after test 2 -> res_data = 0x0008, instr_ready low for the 3 busy cycles.
4. Zero and negative flags:
   - SUBST r3 = r1 - r1 -> res_data = 0, Z = 1.
   - Then with alu_flags[1] forced to 1 -> N = 1.
5. Write to r0 and overflow: write to rd = 0 with 0xFFFF + 1 and alu_flags[2] = 1 -> reg0 stays 0, res_valid still pulses with res_data = 0x0000, status = {V=1, N=0, Z=1}.
6. Reset mid-operation: assert rst_n low during CAP -> no res_valid, destination register unchanged (0 after reset), FSM back in IDLE, instr_ready = 1 one cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the ALU issue front end: ALU op codes,
//                issue FSM state encoding, instruction field positions and
//                status register bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // ALU op codes, carried straight through to alu_mode
   localparam logic [2:0] OP_ADD    = 3'd0;
   localparam logic [2:0] OP_SUBST  = 3'd1;
   localparam logic [2:0] OP_SHIFTR = 3'd2;
   localparam logic [2:0] OP_SHIFTL = 3'd3;
   localparam logic [2:0] OP_AND    = 3'd4;
   localparam logic [2:0] OP_OR     = 3'd5;
   localparam logic [2:0] OP_NOT    = 3'd6;
   localparam logic [2:0] OP_XOR    = 3'd7;

   // Issue FSM states (2-bit encoding)
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OPR  = 2'd1;
   localparam logic [1:0] S_CAP  = 2'd2;
   localparam logic [1:0] S_WB   = 2'd3;

   // Instruction word field positions
   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 13;
   localparam int RD_MSB  = 12;
   localparam int RD_LSB  = 10;
   localparam int RS1_MSB = 9;
   localparam int RS1_LSB = 7;
   localparam int USE_IMM = 6;
   localparam int RS2_MSB = 5;
   localparam int RS2_LSB = 3;
   localparam int IMM_MSB = 5;
   localparam int IMM_LSB = 0;

   // Status register bit positions, status = {V,N,Z}
   localparam int STAT_Z = 0;
   localparam int STAT_N = 1;
   localparam int STAT_V = 2;

   // ALU flag bit positions on alu_flags
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 2;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : alu_regfile
//  Description : General register file. Two combinational read ports, one
//                combinational debug read port and one synchronous write
//                port. Register 0 always reads as zero and ignores writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile
   import alu_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int REG_CNT = 8,
   parameter int AW      = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [AW-1:0]     raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic [AW-1:0]     dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] r_regs [REG_CNT];

   // Register storage: cleared on reset, entry 0 is never written
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_CNT; i++) begin
            r_regs[i] <= {DATA_W{1'b0}};
         end
      end else begin
         for (int i = 1; i < REG_CNT; i++) begin
            if (we && (waddr == AW'(i))) begin
               r_regs[i] <= wdata;
            end
         end
      end
   end

   // Read ports force index 0 to zero so the hard-wired r0 never depends
   // on storage contents
   assign rdata1   = (raddr1   == {AW{1'b0}}) ? {DATA_W{1'b0}} : r_regs[raddr1];
   assign rdata2   = (raddr2   == {AW{1'b0}}) ? {DATA_W{1'b0}} : r_regs[raddr2];
   assign dbg_data = (dbg_addr == {AW{1'b0}}) ? {DATA_W{1'b0}} : r_regs[dbg_addr];

endmodule : alu_regfile
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Front end of the 16-bit ALU. Accepts instructions over a
//                valid/ready handshake, reads operands from the register
//                file, drives the registered ALU inputs, captures the ALU
//                result and flags, and writes the result back while updating
//                the {V,N,Z} status register. One instruction per 4 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int REG_CNT = 8,
   parameter int IMM_W   = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [2:0]        alu_mode,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] alu_flags,
   output logic              res_valid,
   output logic [2:0]        res_rd,
   output logic [DATA_W-1:0] res_data,
   output logic [2:0]        status,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   logic [1:0]        r_state;
   logic [15:0]       r_instr;
   logic [DATA_W-1:0] r_alu_in1;
   logic [DATA_W-1:0] r_alu_in2;
   logic [2:0]        r_alu_mode;
   logic [DATA_W-1:0] r_result;
   logic              r_flag_z;
   logic              r_flag_n;
   logic              r_flag_v;
   logic              r_res_valid;
   logic [2:0]        r_res_rd;
   logic [DATA_W-1:0] r_res_data;
   logic [2:0]        r_status;

   // ------------------------------------------------------------------
   // Decode of the latched instruction
   // ------------------------------------------------------------------
   logic [2:0]        w_op;
   logic [2:0]        w_rd;
   logic [2:0]        w_rs1;
   logic [2:0]        w_rs2;
   logic              w_use_imm;
   logic [IMM_W-1:0]  w_imm;
   logic [DATA_W-1:0] w_imm_ext;
   logic [DATA_W-1:0] w_rdata1;
   logic [DATA_W-1:0] w_rdata2;
   logic              w_accept;
   logic              w_wr_en;
   logic              w_unused_flags;

   assign w_op      = r_instr[OP_MSB:OP_LSB];
   assign w_rd      = r_instr[RD_MSB:RD_LSB];
   assign w_rs1     = r_instr[RS1_MSB:RS1_LSB];
   assign w_rs2     = r_instr[RS2_MSB:RS2_LSB];
   assign w_use_imm = r_instr[USE_IMM];
   assign w_imm     = r_instr[IMM_MSB:IMM_LSB];
   assign w_imm_ext = {{(DATA_W-IMM_W){1'b0}}, w_imm};

   // Only the N and V flags from the ALU are used; Z is derived locally
   assign w_unused_flags = ^{alu_flags[DATA_W-1:FLAG_V+1], alu_flags[0]};

   // Ready is gated by rst_n so nothing is accepted while reset is held
   assign instr_ready = (r_state == S_IDLE) && rst_n;
   assign w_accept    = instr_valid && instr_ready;

   // r0 writes are discarded here and in the register file
   assign w_wr_en = (r_state == S_WB) && (w_rd != 3'd0);

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   alu_regfile #(
      .DATA_W  (DATA_W),
      .REG_CNT (REG_CNT),
      .AW      (3)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (w_wr_en),
      .waddr    (w_rd),
      .wdata    (r_result),
      .raddr1   (w_rs1),
      .rdata1   (w_rdata1),
      .raddr2   (w_rs2),
      .rdata2   (w_rdata2),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // Issue FSM: IDLE -> OPR -> CAP -> WB -> IDLE, one pass per instruction
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_instr <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_instr <= instr;
                  r_state <= S_OPR;
               end
            end
            S_OPR:   r_state <= S_CAP;
            S_CAP:   r_state <= S_WB;
            S_WB:    r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // ALU operand/mode registers: loaded in OPR, held otherwise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_alu_in1  <= {DATA_W{1'b0}};
         r_alu_in2  <= {DATA_W{1'b0}};
         r_alu_mode <= 3'd0;
      end else if (r_state == S_OPR) begin
         r_alu_in1  <= w_rdata1;
         r_alu_in2  <= w_use_imm ? w_imm_ext : w_rdata2;
         r_alu_mode <= w_op;
      end
   end

   // Result capture in CAP, after the ALU inputs have been stable a cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result <= {DATA_W{1'b0}};
         r_flag_z <= 1'b0;
         r_flag_n <= 1'b0;
         r_flag_v <= 1'b0;
      end else if (r_state == S_CAP) begin
         r_result <= alu_out;
         r_flag_z <= (alu_out == {DATA_W{1'b0}});
         r_flag_n <= alu_flags[FLAG_N];
         r_flag_v <= alu_flags[FLAG_V];
      end
   end

   // Writeback report and status update; res_valid is a single-cycle pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_res_valid <= 1'b0;
         r_res_rd    <= 3'd0;
         r_res_data  <= {DATA_W{1'b0}};
         r_status    <= 3'd0;
      end else if (r_state == S_WB) begin
         r_res_valid      <= 1'b1;
         r_res_rd         <= w_rd;
         r_res_data       <= r_result;
         r_status[STAT_Z] <= r_flag_z;
         r_status[STAT_N] <= r_flag_n;
         r_status[STAT_V] <= r_flag_v;
      end else begin
         r_res_valid <= 1'b0;
      end
   end

   assign alu_in1   = r_alu_in1;
   assign alu_in2   = r_alu_in2;
   assign alu_mode  = r_alu_mode;
   assign res_valid = r_res_valid;
   assign res_rd    = r_res_rd;
   assign res_data  = r_res_data;
   assign status    = r_status;

endmodule : alu_issue_ctrl
`default_nettype wire
